escalonador_round_robin: RTL

- Round-robin process scheduler for the multiprogrammed processor.
- Holds a process table with state and saved PC per slot.
- Reacts to context-switch, I/O-block and process-end events from the quantum counter/control unit, then selects the next READY process.
- Drives a one-cycle PC redirect into the PC update logic, or redirects to the OS idle loop when no process is READY.

---
 rtl/escalonador_round_robin_pkg.sv | 10 +
 rtl/escalonador_round_robin_if.sv | 29 ++
 rtl/escalonador_round_robin_tabela_processos.sv | 58 +++++
 rtl/escalonador_round_robin.sv | 106 ++++++++++
 4 files changed

// File: rtl/escalonador_round_robin_pkg.sv
// escalonador_round_robin_pkg: shared encodings and defaults for the round-robin scheduler
// Contents: slot state, FSM state and event kind encodings; default table size and idle PC.
package escalonador_round_robin_pkg;
   localparam int MAX_PROC_DEF = 8;
   localparam int PID_W_DEF = 3;
   localparam logic [31:0] IDLE_PC_DEF = 32'd0;
   typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_RUNNING, SLOT_BLOCKED} slot_t;
   typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_SAVE, ST_SEARCH, ST_DISPATCH} fsm_t;
   typedef enum logic [1:0] {EV_TROCA, EV_IO, EV_FIM} evento_t;
endpackage

// File: rtl/escalonador_round_robin_if.sv
// escalonador_round_robin_if: control-unit/OS <-> scheduler signal bundle
// master: event, creation and I/O-completion sources; slave: the scheduler (redirect + status).
interface escalonador_round_robin_if #(parameter int PID_W = 3);
   logic troca_contexto;
   logic instrucao_io;
   logic fim_processo;
   logic [31:0] pc_salvo;
   logic io_concluido;
   logic [PID_W-1:0] io_pid;
   logic criar_valid;
   logic [31:0] criar_pc;
   logic criar_ready;
   logic [PID_W-1:0] criar_pid;
   logic desvio_valid;
   logic [31:0] desvio_pc;
   logic [PID_W-1:0] pid_atual;
   logic ocioso;
   logic busy;
   modport master (
      output troca_contexto, instrucao_io, fim_processo, pc_salvo, io_concluido, io_pid,
             criar_valid, criar_pc,
      input  criar_ready, criar_pid, desvio_valid, desvio_pc, pid_atual, ocioso, busy
   );
   modport slave (
      input  troca_contexto, instrucao_io, fim_processo, pc_salvo, io_concluido, io_pid,
             criar_valid, criar_pc,
      output criar_ready, criar_pid, desvio_valid, desvio_pc, pid_atual, ocioso, busy
   );
endinterface

// File: rtl/escalonador_round_robin_tabela_processos.sv
// escalonador_round_robin_tabela_processos: process table, MAX_PROC x (state, saved PC)
// Ports: clock_i/reset_i; FSM write port (wr_*), creation port (criar_*), I/O completion port
//   (io_*), PC read port (rd_*), per-slot ready_o/free_o vectors and lowest-FREE index low_free_o.
module escalonador_round_robin_tabela_processos
   import escalonador_round_robin_pkg::*;
#(
   parameter int MAX_PROC = MAX_PROC_DEF,
   parameter int PID_W = PID_W_DEF
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                wr_en_i,
   input  logic [PID_W-1:0]    wr_pid_i,
   input  slot_t               wr_st_i,
   input  logic                wr_pc_en_i,
   input  logic [31:0]         wr_pc_i,
   input  logic                criar_en_i,
   input  logic [31:0]         criar_pc_i,
   input  logic                io_en_i,
   input  logic [PID_W-1:0]    io_pid_i,
   input  logic [PID_W-1:0]    rd_pid_i,
   output logic [31:0]         rd_pc_o,
   output logic [MAX_PROC-1:0] ready_o,
   output logic [MAX_PROC-1:0] free_o,
   output logic [PID_W-1:0]    low_free_o
);
   slot_t st_q [MAX_PROC];
   logic [31:0] pc_q [MAX_PROC];
   always_comb begin
      ready_o = '0;
      free_o = '0;
      low_free_o = '0;
      for (int i = MAX_PROC - 1; i >= 0; i--) begin
         ready_o[i] = st_q[i] == SLOT_READY;
         free_o[i] = st_q[i] == SLOT_FREE;
         if (st_q[i] == SLOT_FREE) low_free_o = PID_W'(i);
      end
   end
   // The three writers target slots in disjoint states (RUNNING/READY, FREE, BLOCKED),
   // so they never hit the same slot in one cycle.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < MAX_PROC; i++) begin
            st_q[i] <= SLOT_FREE;
            pc_q[i] <= '0;
         end
      end else begin
         if (wr_en_i) st_q[wr_pid_i] <= wr_st_i;
         if (wr_en_i && wr_pc_en_i) pc_q[wr_pid_i] <= wr_pc_i;
         if (criar_en_i) begin
            st_q[low_free_o] <= SLOT_READY;
            pc_q[low_free_o] <= criar_pc_i;
         end
         if (io_en_i && st_q[io_pid_i] == SLOT_BLOCKED) st_q[io_pid_i] <= SLOT_READY;
      end
   end
   assign rd_pc_o = pc_q[rd_pid_i];
endmodule

// File: rtl/escalonador_round_robin.sv
// escalonador_round_robin: round-robin process scheduler issuing one-cycle PC redirects
// Ports: clock_i/reset_i (synchronous, active-high); bus (slave modport): context-switch,
//   I/O-block and end events with pc_salvo, I/O completion, process creation handshake,
//   desvio_valid/desvio_pc redirect, pid_atual, ocioso and busy status.
module escalonador_round_robin
   import escalonador_round_robin_pkg::*;
#(
   parameter int MAX_PROC = MAX_PROC_DEF,
   parameter int PID_W = PID_W_DEF,
   parameter logic [31:0] IDLE_PC = IDLE_PC_DEF
) (
   input logic clock_i,
   input logic reset_i,
   escalonador_round_robin_if.slave bus
);
   fsm_t state_q;
   evento_t ev_q;
   logic [PID_W-1:0] pid_q, idx_q, cnt_q, criar_pid_q, low_free;
   logic [31:0] pcs_q, desvio_pc_q, rd_pc;
   logic desvio_valid_q, ocioso_q, criar_en, wr_en, wr_pc_en;
   logic [MAX_PROC-1:0] ready, free;
   slot_t wr_st;
   assign criar_en = bus.criar_valid && |free;
   // SAVE retires the running slot; DISPATCH marks the chosen slot (already in pid_q) RUNNING.
   assign wr_en = state_q == ST_SAVE || state_q == ST_DISPATCH;
   assign wr_pc_en = state_q == ST_SAVE && ev_q != EV_FIM;
   assign wr_st = state_q == ST_DISPATCH ? SLOT_RUNNING :
                  ev_q == EV_FIM ? SLOT_FREE : ev_q == EV_IO ? SLOT_BLOCKED : SLOT_READY;
   escalonador_round_robin_tabela_processos #(.MAX_PROC(MAX_PROC), .PID_W(PID_W)) tabela (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .wr_en_i    (wr_en),
      .wr_pid_i   (pid_q),
      .wr_st_i    (wr_st),
      .wr_pc_en_i (wr_pc_en),
      .wr_pc_i    (pcs_q),
      .criar_en_i (criar_en),
      .criar_pc_i (bus.criar_pc),
      .io_en_i    (bus.io_concluido),
      .io_pid_i   (bus.io_pid),
      .rd_pid_i   (idx_q),
      .rd_pc_o    (rd_pc),
      .ready_o    (ready),
      .free_o     (free),
      .low_free_o (low_free)
   );
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         ev_q <= EV_TROCA;
         pid_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         criar_pid_q <= '0;
         pcs_q <= '0;
         desvio_pc_q <= '0;
         desvio_valid_q <= 1'b0;
         ocioso_q <= 1'b1;
      end else begin
         desvio_valid_q <= 1'b0;
         if (criar_en) criar_pid_q <= low_free;
         case (state_q)
            ST_IDLE: if (|ready) begin
               state_q <= ST_SEARCH;
               idx_q <= pid_q + 1'b1;
               cnt_q <= '0;
            end
            ST_RUN: if (bus.fim_processo || bus.instrucao_io || bus.troca_contexto) begin
               ev_q <= bus.fim_processo ? EV_FIM : bus.instrucao_io ? EV_IO : EV_TROCA;
               pcs_q <= bus.pc_salvo;
               state_q <= ST_SAVE;
            end
            ST_SAVE: begin
               state_q <= ST_SEARCH;
               idx_q <= pid_q + 1'b1;
               cnt_q <= '0;
            end
            // Starting at pid+1 and wrapping makes the previous owner the last candidate.
            ST_SEARCH: if (ready[idx_q]) begin
               state_q <= ST_DISPATCH;
               pid_q <= idx_q;
               desvio_pc_q <= rd_pc;
               desvio_valid_q <= 1'b1;
               ocioso_q <= 1'b0;
            end else if (cnt_q == PID_W'(MAX_PROC - 1)) begin
               state_q <= ST_IDLE;
               desvio_pc_q <= IDLE_PC;
               desvio_valid_q <= 1'b1;
               ocioso_q <= 1'b1;
            end else begin
               idx_q <= idx_q + 1'b1;
               cnt_q <= cnt_q + 1'b1;
            end
            ST_DISPATCH: state_q <= ST_RUN;
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign bus.criar_ready = |free;
   assign bus.criar_pid = criar_pid_q;
   assign bus.desvio_valid = desvio_valid_q;
   assign bus.desvio_pc = desvio_pc_q;
   assign bus.pid_atual = pid_q;
   assign bus.ocioso = ocioso_q;
   assign bus.busy = state_q inside {ST_SAVE, ST_SEARCH, ST_DISPATCH};
endmodule
